// File: rtl/status_pkg.sv
// Shared definitions for the status flag unit: status bit positions,
// the mask of software-clearable sticky bits and the trap FSM states.
package status_pkg;

  localparam int Z_BIT    = 0;
  localparam int N_BIT    = 1;
  localparam int V_BIT    = 2;
  localparam int C_BIT    = 3;
  localparam int DZ_BIT   = 4;
  localparam int MV_BIT   = 5;
  localparam int TRAP_BIT = 6;
  localparam int SERR_BIT = 7;

  // DZ, MV and SERR are the only bits software may clear
  localparam logic [7:0] STICKY_MASK = 8'b1011_0000;

  typedef enum logic {
    NORMAL = 1'b0,
    TRAP   = 1'b1
  } state_t;

endpackage

// File: rtl/status_save_stack.sv
// LIFO holding saved status words across nested traps. dout always shows
// the top entry; it is meaningless while empty. Entries are never reset.
module status_save_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] top_idx;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign top_idx = count - CNT_W'(1);
  assign dout    = mem[top_idx[IDX_W-1:0]];

  // Storage write at the next free slot; contents need no reset
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[count[IDX_W-1:0]] <= din;
    end
  end

  // Occupancy counter; a simultaneous push and pop is never issued
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/status_flag_unit.sv
// Status register beside the ALU: condition flags, W1C sticky exception
// flags and a trap FSM that saves/restores Z/N/V/C on a LIFO stack.
module status_flag_unit #(
  parameter int DATA_W     = 20,
  parameter int TRAP_DEPTH = 4,
  parameter int MEM_LIMIT  = 4095
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              alu_valid,
  input  logic                              alu_sub,
  input  logic [DATA_W-1:0]                 alu_a,
  input  logic [DATA_W-1:0]                 alu_b,
  input  logic [DATA_W-1:0]                 alu_result,
  input  logic                              alu_carry,
  input  logic                              div_zero,
  input  logic                              mem_access,
  input  logic [DATA_W-1:0]                 mem_addr,
  input  logic                              trap_req,
  input  logic                              trap_ret,
  input  logic                              csr_we,
  input  logic [DATA_W-1:0]                 csr_wdata,
  output logic [DATA_W-1:0]                 status_out,
  output logic                              trap_ack,
  output logic [$clog2(TRAP_DEPTH+1)-1:0]   trap_depth
);

  import status_pkg::*;

  localparam int CNT_W = $clog2(TRAP_DEPTH + 1);
  localparam logic [DATA_W-1:0] MEM_LIMIT_W = DATA_W'(MEM_LIMIT);

  state_t     state, state_next;
  logic [3:0] cond_q, cond_alu;
  logic       dz_q, mv_q, serr_q;
  logic       do_push, do_pop, serr_evt;
  logic       stack_full, stack_empty;
  logic [7:0] stack_dout, status_low, clr;
  logic       a_msb, b_msb, r_msb, ovf;
  logic       unused_ok;

  assign a_msb = alu_a[DATA_W-1];
  assign b_msb = alu_b[DATA_W-1];
  assign r_msb = alu_result[DATA_W-1];
  assign ovf   = alu_sub ? ((a_msb != b_msb) && (r_msb != a_msb))
                         : ((a_msb == b_msb) && (r_msb != a_msb));

  assign cond_alu[Z_BIT] = (alu_result == '0);
  assign cond_alu[N_BIT] = r_msb;
  assign cond_alu[V_BIT] = ovf;
  assign cond_alu[C_BIT] = alu_carry;

  assign clr = csr_we ? (csr_wdata[7:0] & STICKY_MASK) : 8'h00;

  // Low byte of the status word; also the value saved on trap entry
  always_comb begin
    status_low           = '0;
    status_low[3:0]      = cond_q;
    status_low[DZ_BIT]   = dz_q;
    status_low[MV_BIT]   = mv_q;
    status_low[TRAP_BIT] = (state == TRAP);
    status_low[SERR_BIT] = serr_q;
  end

  // Bits 8 and above always read zero
  always_comb begin
    status_out      = '0;
    status_out[7:0] = status_low;
  end

  status_save_stack #(
    .WIDTH (8),
    .DEPTH (TRAP_DEPTH),
    .CNT_W (CNT_W)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (do_push),
    .pop   (do_pop),
    .din   (status_low),
    .dout  (stack_dout),
    .count (trap_depth),
    .full  (stack_full),
    .empty (stack_empty)
  );

  // Trap FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= NORMAL;
    end else begin
      state <= state_next;
    end
  end

  // Trap FSM: request beats return; overflow/underflow raise SERR
  always_comb begin
    state_next = state;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    serr_evt   = 1'b0;
    if (trap_req) begin
      if (stack_full) begin
        serr_evt = 1'b1;
      end else begin
        do_push    = 1'b1;
        state_next = TRAP;
      end
    end else if (trap_ret) begin
      if (stack_empty) begin
        serr_evt = 1'b1;
      end else begin
        do_pop = 1'b1;
        if (trap_depth == CNT_W'(1)) begin
          state_next = NORMAL;
        end
      end
    end
  end

  // Entry acknowledge, one cycle after an accepted request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trap_ack <= 1'b0;
    end else begin
      trap_ack <= do_push;
    end
  end

  // Condition flags (popped values beat a new ALU result) and sticky flags (set beats clear)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cond_q <= '0;
      dz_q   <= 1'b0;
      mv_q   <= 1'b0;
      serr_q <= 1'b0;
    end else begin
      if (do_pop) begin
        cond_q <= stack_dout[3:0];
      end else if (alu_valid) begin
        cond_q <= cond_alu;
      end
      dz_q   <= (alu_valid && div_zero) || (dz_q && !clr[DZ_BIT]);
      mv_q   <= (mem_access && (mem_addr > MEM_LIMIT_W)) || (mv_q && !clr[MV_BIT]);
      serr_q <= serr_evt || (serr_q && !clr[SERR_BIT]);
    end
  end

  // Operand/mask bits that only partially feed the flag logic
  assign unused_ok = ^{alu_a, alu_b, csr_wdata, stack_dout};

endmodule
